timer_mode_ctrl: RTL and testbench
==================================

Name: timer_mode_ctrl

Overview:
- Control FSM for the two-mode timer: count-up stopwatch (mode 0) or count-down timer (mode 1).
- Owns the tick prescaler and the count register.
- Drives the enable of the display D-latch bank: transparent normally, closed during a lap hold, so the display freezes while counting continues.
- Sits between the debounced button pulses and the latch/display datapath.

Parameters:
- TICK_DIV, 100: clk cycles per count tick (min 2).
- CNT_W, 16: count width.
- MAX_COUNT, 5999: highest count value. Up-count wraps here; loads saturate here. Must fit in CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- mode_sel  in  1  0 = count up, 1 = count down. Sampled only in IDLE.
- start_stop  in  1  single-cycle pulse: start / pause / resume.
- lap  in  1  single-cycle pulse: toggle display hold.
- load  in  1  single-cycle pulse: load load_val.
- load_val  in  CNT_W  preset value.
- count  out  CNT_W  live count; feeds latch D inputs.
- hold_en  out  1  display-latch enable. 1 = transparent, 0 = hold.
- running  out  1  high in RUN and HOLD.
- expired  out  1  count-down reached zero.

Behaviour:
- Reset values: state IDLE, count 0, prescaler 0, mode register 0, reload register 0, hold_en 1, running 0, expired 0.
  - rst mid-operation aborts any state in the same edge.
- States: IDLE, RUN, PAUSE, HOLD, DONE. All outputs are registered or decoded from state; none are combinational from inputs.
- Priority for same-cycle events: rst > load > start_stop > lap.
- IDLE:
  - mode register <= mode_sel every cycle.
  - start_stop -> RUN. Exception: mode 1 with count==0 stays IDLE.
  - lap ignored.
- RUN:
  - prescaler counts 0..TICK_DIV-1; tick when prescaler==TICK_DIV-1.
  - First count change is visible TICK_DIV cycles after the edge that entered RUN.
  - start_stop -> PAUSE.
  - lap -> HOLD.
  - load ignored.
- HOLD:
  - Counting continues exactly as in RUN; hold_en=0.
  - lap -> RUN.
  - start_stop -> PAUSE, hold_en returns to 1 in the same transition.
- PAUSE:
  - prescaler frozen (not cleared); resume continues the partial tick.
  - start_stop -> RUN.
  - lap ignored.
- DONE:
  - count=0, expired=1.
  - start_stop -> IDLE and clears expired.
  - lap ignored.
- Tick arithmetic:
  - Mode 0: count+1; MAX_COUNT wraps to 0.
  - Mode 1: count-1. The tick that makes count 0 moves to DONE on the same edge.
  - If a lap is pending on that tick edge, HOLD is overridden and DONE wins; hold_en returns to 1.
- Load:
  - Accepted in IDLE, PAUSE and DONE.
  - count <= min(load_val, MAX_COUNT); reload register <= same value.
  - prescaler <= 0; expired <= 0; state -> IDLE.
- mode_sel changes outside IDLE have no effect.
- hold_en = 0 only in HOLD.
- running = RUN or HOLD.

Optional Feature:
- Macro: TIMER_MODE_CTRL_AUTORELOAD_EN.
- Defined:
  - In mode 1, the tick reaching 0 reloads count from the reload register and stays in RUN/HOLD.
  - expired is a one-cycle pulse; DONE is unreachable.
  - If the reload register is 0, behaves as undefined macro.
- Undefined: behaviour as above. No reload register is synthesised (load still saturates count).

Decomposition:
- Package timer_pkg:
  - state enum (IDLE, RUN, PAUSE, HOLD, DONE);
  - MODE_UP/MODE_DOWN constants;
  - default CNT_W/MAX_COUNT/TICK_DIV.
- Sub-module tick_prescaler:
  - ports: clk, rst, en, clr, tick; parameter TICK_DIV.
  - en is high in RUN/HOLD; clr is asserted on load and on entry to IDLE.

Test Plan (TICK_DIV=4, MAX_COUNT=9, CNT_W=8):
1. Reset, mode 0, start_stop -> count 1 at cycle 4, 2 at cycle 8. At 9, next tick wraps to 0. running=1, hold_en=1.
2. RUN count 3, lap -> hold_en=0 while count reaches 5. lap -> hold_en=1. start_stop -> PAUSE, count frozen 20 cycles.
3. Load 7, mode 1, start -> count 6,5,...,0 every 4 cycles. State DONE, expired=1 at the 0 edge. start_stop -> IDLE, expired=0.
4. Load 200 -> count=9 (saturated). Same-cycle load+start_stop in PAUSE -> load wins, IDLE. mode_sel toggled in RUN -> no direction change.
5. rst asserted in HOLD mid-tick -> next cycle count=0, hold_en=1, running=0, IDLE.
6. With TIMER_MODE_CTRL_AUTORELOAD_EN: load 2, mode 1, start -> sequence 1,0->2,1,... expired pulses 1 cycle per reload. Without it: DONE after first 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and defaults for the two-mode (stopwatch / count-down) timer.
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    localparam int unsigned DEF_CNT_W     = 16;
    localparam int unsigned DEF_MAX_COUNT = 5999;
    localparam int unsigned DEF_TICK_DIV  = 100;

endpackage

// File: rtl/timer_mode_ctrl_tick_prescaler.sv
// Free-running tick divider: one tick every TICK_DIV enabled cycles, frozen when disabled.
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = (pre_q == LAST) ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick = en && (pre_q == LAST);

endmodule

// File: rtl/timer_mode_ctrl.sv
// Two-mode timer control FSM: owns the count register and drives the display-latch enable.
// Optional macro TIMER_MODE_CTRL_AUTORELOAD_EN: count-down reloads instead of stopping at zero.
module timer_mode_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned MAX_COUNT = DEF_MAX_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_sel,
    input  logic             start_stop,
    input  logic             lap,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             hold_en,
    output logic             running,
    output logic             expired
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             expired_q, expired_d;
    logic             load_acc;
    logic             tick;
    logic             pre_en;
    logic             pre_clr;
    logic [CNT_W-1:0] load_sat;

`ifdef TIMER_MODE_CTRL_AUTORELOAD_EN
    logic [CNT_W-1:0] reload_q, reload_d;
`endif

    assign load_sat = (load_val > MAX_C) ? MAX_C : load_val;
    assign pre_en   = (state_q == ST_RUN) || (state_q == ST_HOLD);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mode_d    = mode_q;
        expired_d = expired_q;
        load_acc  = 1'b0;
`ifdef TIMER_MODE_CTRL_AUTORELOAD_EN
        reload_d  = reload_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                mode_d = mode_sel;
                if (load) begin
                    load_acc = 1'b1;
                end else if (start_stop && !(mode_sel == MODE_DOWN && count_q == '0)) begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (load) begin
                    load_acc = 1'b1;
                end else if (start_stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (load) begin
                    load_acc = 1'b1;
                end else if (start_stop) begin
                    state_d   = ST_IDLE;
                    expired_d = 1'b0;
                end
            end
            ST_RUN, ST_HOLD: begin
                expired_d = 1'b0;
                if (start_stop) begin
                    state_d = ST_PAUSE;
                end else if (lap) begin
                    state_d = (state_q == ST_RUN) ? ST_HOLD : ST_RUN;
                end
                // Tick handling runs after the button decode so reaching zero overrides any pending transition.
                if (tick) begin
                    if (mode_q == MODE_UP) begin
                        count_d = (count_q >= MAX_C) ? '0 : count_q + 1'b1;
                    end else if (count_q <= ONE_C) begin
`ifdef TIMER_MODE_CTRL_AUTORELOAD_EN
                        if (reload_q != '0) begin
                            count_d   = reload_q;
                            expired_d = 1'b1;
                        end else begin
                            count_d   = '0;
                            expired_d = 1'b1;
                            state_d   = ST_DONE;
                        end
`else
                        count_d   = '0;
                        expired_d = 1'b1;
                        state_d   = ST_DONE;
`endif
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_acc) begin
            count_d   = load_sat;
            expired_d = 1'b0;
            state_d   = ST_IDLE;
`ifdef TIMER_MODE_CTRL_AUTORELOAD_EN
            reload_d  = load_sat;
`endif
        end
    end

    assign pre_clr = load_acc || ((state_d == ST_IDLE) && (state_q != ST_IDLE));

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (pre_en),
        .clr (pre_clr),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            mode_q    <= MODE_UP;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            expired_q <= expired_d;
        end
    end

`ifdef TIMER_MODE_CTRL_AUTORELOAD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign count   = count_q;
    assign hold_en = (state_q != ST_HOLD);
    assign running = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign expired = expired_q;

endmodule

// File: tb/tb_timer_mode_ctrl.sv
// Scoreboard bench for timer_mode_ctrl (TICK_DIV=4, MAX_COUNT=9, CNT_W=8).
module tb_timer_mode_ctrl;

    localparam int TD = 4;
    localparam int MX = 9;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode_sel = 1'b0;
    logic          start_stop = 1'b0;
    logic          lap = 1'b0;
    logic          load = 1'b0;
    logic [CW-1:0] load_val = '0;
    logic [CW-1:0] count;
    logic          hold_en;
    logic          running;
    logic          expired;

    timer_mode_ctrl #(
        .TICK_DIV (TD),
        .CNT_W    (CW),
        .MAX_COUNT(MX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_sel  (mode_sel),
        .start_stop(start_stop),
        .lap       (lap),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .hold_en   (hold_en),
        .running   (running),
        .expired   (expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit hen;
        bit run;
        bit exp;
    } exp_t;

    exp_t sbq[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit ms_v     = 1'b0;

    // Reference model: 0 IDLE, 1 RUN, 2 PAUSE, 3 HOLD, 4 DONE
    int m_st, m_cnt, m_pre, m_mode, m_rel, m_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_load(input int lv);
        m_cnt = (lv > MX) ? MX : lv;
        m_rel = m_cnt;
        m_pre = 0;
        m_exp = 0;
        m_st  = 0;
    endtask

    task automatic model_edge(input bit rs, input bit ss, input bit lp, input bit ld,
                              input int lv, input bit ms);
        bit tk;
        if (rs) begin
            m_st = 0; m_cnt = 0; m_pre = 0; m_mode = 0; m_rel = 0; m_exp = 0;
            return;
        end
        case (m_st)
            0: begin
                m_mode = ms;
                if (ld) model_load(lv);
                else if (ss && !(ms && m_cnt == 0)) m_st = 1;
            end
            2: begin
                if (ld) model_load(lv);
                else if (ss) m_st = 1;
            end
            4: begin
                if (ld) model_load(lv);
                else if (ss) begin m_st = 0; m_exp = 0; m_pre = 0; end
            end
            default: begin
                tk    = (m_pre == TD - 1);
                m_pre = tk ? 0 : m_pre + 1;
                m_exp = 0;
                if (ss) m_st = 2;
                else if (lp) m_st = (m_st == 1) ? 3 : 1;
                if (tk) begin
                    if (m_mode == 0) begin
                        m_cnt = (m_cnt == MX) ? 0 : m_cnt + 1;
                    end else begin
                        m_cnt = m_cnt - 1;
                        if (m_cnt == 0) begin
                            m_exp = 1;
`ifdef TIMER_MODE_CTRL_AUTORELOAD_EN
                            if (m_rel != 0) m_cnt = m_rel;
                            else m_st = 4;
`else
                            m_st = 4;
`endif
                        end
                    end
                end
            end
        endcase
    endtask

    task automatic step(input bit rs, input bit ss, input bit lp, input bit ld, input int lv);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst        = rs;
        start_stop = ss;
        lap        = lp;
        load       = ld;
        load_val   = lv[CW-1:0];
        mode_sel   = ms_v;
        model_edge(rs, ss, lp, ld, lv, ms_v);
        e.cnt = m_cnt;
        e.hen = (m_st != 3);
        e.run = (m_st == 1) || (m_st == 3);
        e.exp = (m_exp != 0);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        g = sbq.pop_front();
        chk("sb_count",   32'(count),   32'(g.cnt));
        chk("sb_hold_en", 32'(hold_en), 32'(g.hen));
        chk("sb_running", 32'(running), 32'(g.run));
        chk("sb_expired", 32'(expired), 32'(g.exp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        m_st = 0; m_cnt = 0; m_pre = 0; m_mode = 0; m_rel = 0; m_exp = 0;

        // Reset and stopwatch counting with wrap
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_hold_en", 32'(hold_en), 1);
        chk("rst_running", 32'(running), 0);
        chk("rst_expired", 32'(expired), 0);
        step(0, 1, 0, 0, 0);
        idle(3);
        chk("up_before_tick", 32'(count), 0);
        idle(1);
        chk("up_first_tick", 32'(count), 1);
        chk("up_running", 32'(running), 1);
        chk("up_hold_en", 32'(hold_en), 1);
        idle(4);
        chk("up_second_tick", 32'(count), 2);
        idle(28);
        chk("up_at_max", 32'(count), 9);
        idle(4);
        chk("up_wrap", 32'(count), 0);

        // Lap hold, release, pause
        idle(12);
        chk("lap_start_cnt", 32'(count), 3);
        step(0, 0, 1, 0, 0);
        chk("lap_hold_en", 32'(hold_en), 0);
        idle(7);
        chk("lap_count_live", 32'(count), 5);
        chk("lap_still_held", 32'(hold_en), 0);
        step(0, 0, 1, 0, 0);
        chk("lap_release", 32'(hold_en), 1);
        step(0, 1, 0, 0, 0);
        chk("pause_running", 32'(running), 0);
        idle(20);
        chk("pause_frozen", 32'(count), 5);

        // Count-down to DONE
        ms_v = 1'b1;
        step(0, 0, 0, 1, 7);
        chk("dn_load", 32'(count), 7);
        step(0, 1, 0, 0, 0);
        idle(4);
        chk("dn_first", 32'(count), 6);
        idle(24);
        chk("dn_zero", 32'(count), 0);
        chk("dn_expired", 32'(expired), 1);
        chk("dn_done_stop", 32'(running), 0);
        step(0, 1, 0, 0, 0);
        chk("dn_ack_expired", 32'(expired), 0);
        step(0, 1, 0, 0, 0);
        chk("dn_zero_nostart", 32'(running), 0);

        // Lap on the zero-reaching tick: DONE wins
        step(0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 0);
        idle(3);
        step(0, 0, 1, 0, 0);
        chk("dn_lap_exp", 32'(expired), 1);
        chk("dn_lap_hold_en", 32'(hold_en), 1);
        chk("dn_lap_running", 32'(running), 0);

        // Saturating load, load beats start_stop, mode locked outside IDLE
        step(0, 0, 0, 1, 200);
        chk("load_sat", 32'(count), 9);
        ms_v = 1'b0;
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 3);
        chk("load_prio_cnt", 32'(count), 3);
        chk("load_prio_idle", 32'(running), 0);
        step(0, 1, 0, 0, 0);
        ms_v = 1'b1;
        idle(4);
        chk("mode_locked", 32'(count), 4);

        // Reset mid-tick in HOLD
        step(0, 0, 1, 0, 0);
        idle(2);
        step(1, 0, 0, 0, 0);
        chk("rst_hold_cnt", 32'(count), 0);
        chk("rst_hold_en", 32'(hold_en), 1);
        chk("rst_hold_run", 32'(running), 0);

        // Reload behaviour
        ms_v = 1'b1;
        step(0, 0, 0, 1, 2);
        step(0, 1, 0, 0, 0);
        idle(4);
        chk("rl_first", 32'(count), 1);
        idle(4);
`ifdef TIMER_MODE_CTRL_AUTORELOAD_EN
        chk("rl_reload_cnt", 32'(count), 2);
        chk("rl_pulse", 32'(expired), 1);
        chk("rl_running", 32'(running), 1);
        idle(1);
        chk("rl_pulse_end", 32'(expired), 0);
`else
        chk("rl_done_cnt", 32'(count), 0);
        chk("rl_done_exp", 32'(expired), 1);
        chk("rl_done_run", 32'(running), 0);
        idle(1);
        chk("rl_done_hold", 32'(expired), 1);
`endif

        // Random button traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 19) == 0) ms_v = ~ms_v;
            step(r == 11, r < 4, (r >= 4) && (r < 8), (r >= 8) && (r < 11),
                 $urandom_range(0, 15));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
